// File: rtl/adder_pkg.sv
// Shared types and defaults for the pipelined adder family.
package adder_pkg;

  typedef enum logic {MODE_WRAP, MODE_SAT} add_mode_t;

  localparam int DEFAULT_BIT_WIDTH  = 16;
  localparam int DEFAULT_NUM_STAGES = 4;

endpackage

// File: rtl/adder_nbit.sv
// Combinational unsigned N-bit adder; overflow is the carry out of the MSB.
module adder_nbit #(
  parameter int BIT_WIDTH = 16
) (
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 carry_in,
  output logic [BIT_WIDTH-1:0] sum,
  output logic                 overflow
);

  assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {{BIT_WIDTH{1'b0}}, carry_in};

endmodule

// File: rtl/adder_pipe_nbit.sv
// Pipelined unsigned adder: one ripple slice per stage, valid/ready handshake
// with a single global advance, optional saturation on the final result.
module adder_pipe_nbit
  import adder_pkg::*;
#(
  parameter int        BIT_WIDTH  = DEFAULT_BIT_WIDTH,
  parameter int        NUM_STAGES = DEFAULT_NUM_STAGES,
  parameter add_mode_t MODE       = MODE_WRAP
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 carry_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] sum,
  output logic                 overflow
);

  localparam int SLICE_W = BIT_WIDTH / NUM_STAGES;

  if (BIT_WIDTH % NUM_STAGES != 0) begin : g_bad_cfg
    $fatal(1, "adder_pipe_nbit: BIT_WIDTH must be a multiple of NUM_STAGES");
  end

  // Index k holds what stage k consumes; index k+1 is written by stage k.
  // Operands are pre-shifted so stage k always adds bits [SLICE_W-1:0].
  logic [BIT_WIDTH-1:0] w_op_a  [NUM_STAGES];
  logic [BIT_WIDTH-1:0] w_op_b  [NUM_STAGES];
  logic [BIT_WIDTH-1:0] w_sum_q [NUM_STAGES+1];
  logic                 w_cy_q  [NUM_STAGES+1];
  logic                 w_vld_q [NUM_STAGES+1];
  logic                 w_adv;

  assign w_adv      = !out_valid || out_ready;
  assign in_ready   = w_adv;

  assign w_op_a[0]  = a;
  assign w_op_b[0]  = b;
  assign w_sum_q[0] = '0;
  assign w_cy_q[0]  = carry_in;
  assign w_vld_q[0] = in_valid;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    logic [SLICE_W-1:0]   w_slice_sum;
    logic                 w_slice_cy;
    logic [BIT_WIDTH-1:0] w_sum_next;
    logic [BIT_WIDTH-1:0] r_sum;
    logic                 r_cy;
    logic                 r_vld;

    adder_nbit #(.BIT_WIDTH(SLICE_W)) u_slice (
      .a        (w_op_a[k][SLICE_W-1:0]),
      .b        (w_op_b[k][SLICE_W-1:0]),
      .carry_in (w_cy_q[k]),
      .sum      (w_slice_sum),
      .overflow (w_slice_cy)
    );

    // Deskew: completed slices enter at the top and shift down one slice per
    // stage, landing at k*SLICE_W after the last stage.
    assign w_sum_next = (w_sum_q[k] >> SLICE_W)
                      | (BIT_WIDTH'(w_slice_sum) << (BIT_WIDTH - SLICE_W));

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's pre-edge value, giving a true shift pipeline.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_vld <= 1'b0;
        r_cy  <= 1'b0;
        r_sum <= '0;
      end else if (w_adv) begin
        r_vld <= w_vld_q[k];
        r_cy  <= w_slice_cy;
        r_sum <= w_sum_next;
      end
    end

    assign w_sum_q[k+1] = r_sum;
    assign w_cy_q[k+1]  = r_cy;
    assign w_vld_q[k+1] = r_vld;

    if (k < NUM_STAGES - 1) begin : g_skew
      logic [BIT_WIDTH-1:0] r_op_a;
      logic [BIT_WIDTH-1:0] r_op_b;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_op_a <= '0;
          r_op_b <= '0;
        end else if (w_adv) begin
          r_op_a <= w_op_a[k] >> SLICE_W;
          r_op_b <= w_op_b[k] >> SLICE_W;
        end
      end

      assign w_op_a[k+1] = r_op_a;
      assign w_op_b[k+1] = r_op_b;
    end
  end

  assign out_valid = w_vld_q[NUM_STAGES];
  assign overflow  = w_cy_q[NUM_STAGES];
  assign sum       = (MODE == MODE_SAT && overflow) ? '1 : w_sum_q[NUM_STAGES];

  // Simulation-only guard against unknown operands entering the pipe.
  always @(posedge clk) begin
    if (in_valid) begin
      assert (!$isunknown({a, b}))
        else $error("adder_pipe_nbit: unknown bits on a/b while in_valid=1");
    end
  end

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Directed bench for adder_pipe_nbit: 4-stage wrap, 4-stage saturating and
// 1-stage instances driven from one linear stimulus sequence.
module tb_adder_pipe_nbit;
  import adder_pkg::*;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] s;
    logic         ov;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b;
  logic         carry_in, in_valid, out_ready;
  logic         in_ready, out_valid, overflow;
  logic [W-1:0] sum;
  logic         in_ready_s, out_valid_s, overflow_s;
  logic [W-1:0] sum_s;
  logic         in_valid1, out_ready1, in_ready1, out_valid1, overflow1;
  logic [W-1:0] sum1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adder_pipe_nbit #(.BIT_WIDTH(W), .NUM_STAGES(4), .MODE(MODE_WRAP)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .carry_in(carry_in),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .overflow(overflow)
  );

  adder_pipe_nbit #(.BIT_WIDTH(W), .NUM_STAGES(4), .MODE(MODE_SAT)) dut_sat (
    .clk(clk), .rst(rst), .a(a), .b(b), .carry_in(carry_in),
    .in_valid(in_valid), .in_ready(in_ready_s), .out_valid(out_valid_s),
    .out_ready(out_ready), .sum(sum_s), .overflow(overflow_s)
  );

  adder_pipe_nbit #(.BIT_WIDTH(W), .NUM_STAGES(1), .MODE(MODE_WRAP)) dut1 (
    .clk(clk), .rst(rst), .a(a), .b(b), .carry_in(carry_in),
    .in_valid(in_valid1), .in_ready(in_ready1), .out_valid(out_valid1),
    .out_ready(out_ready1), .sum(sum1), .overflow(overflow1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  // Single transaction through the 4-stage pair with out_ready held high.
  task automatic run_one(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tc, input logic [W-1:0] exp_s, input logic exp_ov,
                         input logic [W-1:0] exp_sat);
    int lat;
    a = ta; b = tb_; carry_in = tc; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_sum"}, sum, exp_s);
    check({tag, "_ovf"}, overflow, exp_ov);
    check({tag, "_sat_sum"}, sum_s, exp_sat);
    check({tag, "_sat_ovf"}, overflow_s, exp_ov);
    @(posedge clk); #1;
    check({tag, "_drained"}, out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs [8];
    int           sent, rcvd, cyc;
    logic         hold_v, hold_o, seen;
    logic [W-1:0] hold_s;

    vecs[0] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0};
    vecs[1] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1};
    vecs[3] = '{16'h1111, 16'h2222, 1'b1, 16'h3334, 1'b0};
    vecs[4] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0};
    vecs[5] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};
    vecs[6] = '{16'hFFF0, 16'h0010, 1'b0, 16'h0000, 1'b1};
    vecs[7] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0};

    // Reset with random activity on the inputs.
    rst = 1'b1;
    a = 16'($urandom); b = 16'($urandom); carry_in = 1'b1;
    in_valid = 1'b1; out_ready = 1'($urandom_range(0, 1));
    in_valid1 = 1'b1; out_ready1 = 1'b0;
    #1;
    check("rst_sum", sum, 16'h0000);
    check("rst_ovf", overflow, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_out_valid", out_valid, 1'b0);
    check("rst_hold_sum", sum, 16'h0000);
    check("rst_sat_sum", sum_s, 16'h0000);
    check("rst_1stage_valid", out_valid1, 1'b0);

    in_valid = 1'b0; in_valid1 = 1'b0; out_ready = 1'b1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid || out_valid1) seen = 1'b1;
    end
    check("post_rst_idle", seen, 1'b0);

    // Directed single transactions.
    run_one("basic",   16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 16'h5555);
    run_one("xslice",  16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 16'h0100);
    run_one("ripple",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 16'hFFFF);
    run_one("max",     16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 16'hFFFF);

    // Back-to-back stream with backpressure; first cycles stall to fill the pipe.
    sent = 0; rcvd = 0; cyc = 0; hold_v = 1'b0; hold_s = '0; hold_o = 1'b0;
    while (rcvd < 8 && cyc < 300) begin
      out_ready = (cyc < 6) ? 1'b0 : 1'($urandom_range(0, 1));
      if (sent < 8) begin
        a = vecs[sent].a; b = vecs[sent].b; carry_in = vecs[sent].c; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      check("bp_in_ready", in_ready, !(out_valid && !out_ready));
      if (hold_v) begin
        check("bp_stall_valid", out_valid, 1'b1);
        check("bp_stall_sum", sum, hold_s);
        check("bp_stall_ovf", overflow, hold_o);
      end
      if (out_valid && out_ready) begin
        check("bp_sum", sum, vecs[rcvd].s);
        check("bp_ovf", overflow, vecs[rcvd].ov);
        rcvd++;
      end
      hold_v = out_valid && !out_ready;
      hold_s = sum;
      hold_o = overflow;
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    check("bp_all_received", rcvd, 8);
    in_valid = 1'b0; out_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("bp_no_duplicate", seen, 1'b0);

    // Reset with three transactions in flight, one already at the output.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = vecs[i + 3].a; b = vecs[i + 3].b; carry_in = vecs[i + 3].c; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_pre_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_sum", sum, 16'h0000);
    check("mid_rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("mid_nothing_emitted", seen, 1'b0);

    // Single-stage instance: latency of one edge.
    a = 16'h1234; b = 16'h4321; carry_in = 1'b0; in_valid1 = 1'b1; out_ready1 = 1'b1;
    #1;
    check("s1_in_ready", in_ready1, 1'b1);
    check("s1_pre_valid", out_valid1, 1'b0);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    check("s1_valid", out_valid1, 1'b1);
    check("s1_sum", sum1, 16'h5555);
    check("s1_ovf", overflow1, 1'b0);
    @(posedge clk); #1;
    check("s1_drained", out_valid1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
